// File: rtl/button_debounce_multi.sv
// Multi-channel push-button debouncer.
// Each channel is synchronised through two flops, normalised so that 1 means
// pressed, and filtered by its own stability counter. Per channel the block
// produces a clean level, one-cycle press/release strobes and an optional
// one-cycle long-press strobe. Channels share nothing but the clock and reset.
module button_debounce_multi #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int LONG_CYCLES     = 0,
    parameter int ACTIVE_HIGH     = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NUM_CH-1:0] i_buttons,
    output logic [NUM_CH-1:0] o_level,
    output logic [NUM_CH-1:0] o_press,
    output logic [NUM_CH-1:0] o_release,
    output logic [NUM_CH-1:0] o_long
);

    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Pin level that corresponds to "not pressed"
    localparam logic             IDLE_PIN = (ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

    logic [NUM_CH-1:0] sync_p0;
    logic [NUM_CH-1:0] sync_p1;
    logic [NUM_CH-1:0] norm_p1;
    logic [NUM_CH-1:0] accept;

    // Two-flop synchroniser for every raw pin; reset parks it at the idle level
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_p0 <= {NUM_CH{IDLE_PIN}};
            sync_p1 <= {NUM_CH{IDLE_PIN}};
        end else begin
            sync_p0 <= i_buttons;
            sync_p1 <= sync_p0;
        end
    end

    // ---- stage boundary: synchronised sample -> per-channel filter ----
    assign norm_p1 = (ACTIVE_HIGH != 0) ? sync_p1 : ~sync_p1;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic             level_r;
        logic             press_r;
        logic             release_r;

        // A change is accepted on the edge where the disagreement has already
        // persisted for DEBOUNCE_CYCLES-1 counted cycles.
        assign accept[n] = (norm_p1[n] != level_r) && (cnt == CNT_LAST);

        // Stability counter, debounced level and press/release strobes
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                cnt       <= '0;
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                press_r   <= accept[n] &&  norm_p1[n];
                release_r <= accept[n] && !norm_p1[n];
                if ((norm_p1[n] == level_r) || accept[n]) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                if (accept[n]) begin
                    level_r <= norm_p1[n];
                end
            end
        end

        assign o_level[n]   = level_r;
        assign o_press[n]   = press_r;
        assign o_release[n] = release_r;

        // ---- stage boundary: debounced level -> long-press detector ----
        if (LONG_CYCLES > 0) begin : g_long
            localparam int                HCNT_W    = $clog2(LONG_CYCLES + 1);
            localparam logic [HCNT_W-1:0] HCNT_FULL = HCNT_W'(LONG_CYCLES);
            localparam logic [HCNT_W-1:0] HCNT_ARM  = HCNT_W'(LONG_CYCLES - 1);

            logic [HCNT_W-1:0] hcnt;
            logic              long_r;

            // Hold counter saturates at LONG_CYCLES so each press strobes once;
            // a release accepted on the would-be strobe edge suppresses it.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    hcnt   <= '0;
                    long_r <= 1'b0;
                end else begin
                    long_r <= level_r && (hcnt == HCNT_ARM) && !accept[n];
                    if (!level_r) begin
                        hcnt <= '0;
                    end else if (hcnt != HCNT_FULL) begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
            end

            assign o_long[n] = long_r;
        end else begin : g_no_long
            assign o_long[n] = 1'b0;
        end
    end

endmodule

// File: doc/button_debounce_multi.md
# button_debounce_multi

Parametrised multi-channel successor to the single-button debouncer. The block synchronises NUM_CH raw mechanical inputs and filters each one independently with its own stability counter. Per channel it delivers a clean debounced level, one-cycle press and release strobes, and an optional one-cycle long-press strobe. It sits between board pins (buttons, switches) and control logic such as the UART test front-end.

## Interface
Parameters:
- NUM_CH, 4: number of independent channels (≥1).
- DEBOUNCE_CYCLES, 10000: consecutive stable cycles required before a level change is accepted (≥2).
- LONG_CYCLES, 0: held-pressed cycles before o_long strobes. 0 disables long-press detection.
- ACTIVE_HIGH, 1: 1 means the raw pin reads 1 when pressed; 0 means the raw pin reads 0 when pressed.

Ports:
- i_clk, input, 1: single clock. All logic is on the rising edge.
- i_rst, input, 1: asynchronous, active-high reset.
- i_buttons, input, NUM_CH: raw, unsynchronised pin levels.
- o_level, output, NUM_CH: debounced level, normalised so that 1 means pressed.
- o_press, output, NUM_CH: one-cycle strobe on an accepted press.
- o_release, output, NUM_CH: one-cycle strobe on an accepted release.
- o_long, output, NUM_CH: one-cycle strobe when a press has been held for LONG_CYCLES.

## Operation
Each channel is fully independent. There are no shared counters and no cross-channel interaction.

Synchroniser:
- Two flops per channel: s1 ← i_buttons[n], then s2 ← s1.
- On reset, both flops load the inactive pin level (0 when ACTIVE_HIGH=1, 1 when ACTIVE_HIGH=0).
- Normalised sample: norm = s2 when ACTIVE_HIGH=1, otherwise ~s2.

Stability counter (cnt):
- Width is $clog2(DEBOUNCE_CYCLES).
- On each edge where norm == o_level: cnt ← 0.
- On each edge where norm != o_level:
  - If cnt == DEBOUNCE_CYCLES−1: o_level ← norm and cnt ← 0.
  - Otherwise: cnt ← cnt+1.
- Any single cycle of agreement restarts the count. Glitches shorter than DEBOUNCE_CYCLES are therefore fully rejected.
- cnt never exceeds DEBOUNCE_CYCLES−1, so there is no wrap.

Strobes:
- o_press and o_release are registered. They assert on the same edge that o_level rises or falls, for exactly one cycle.
- They are never both high on one channel in the same cycle.

Long press (hcnt):
- Generated only when LONG_CYCLES>0. Otherwise o_long is tied to 0 and hcnt is not built.
- Width is $clog2(LONG_CYCLES+1).
- hcnt ← 0 while o_level==0.
- While o_level==1 and hcnt < LONG_CYCLES, hcnt increments.
- o_long strobes on the edge where hcnt goes from LONG_CYCLES−1 to LONG_CYCLES.
- hcnt then saturates, giving exactly one o_long strobe per press.
- A release clears hcnt, which re-arms detection.

## Timing
Reset values (asynchronous, immediate on i_rst high):
- o_level, o_press, o_release, o_long, cnt and hcnt are all 0.
- The synchroniser flops hold the inactive pin level.

Latency:
- Let edge k be the edge at which s1 first captures a new raw level, and assume the level stays stable.
- o_level changes, and the matching strobe asserts, at edge k+1+DEBOUNCE_CYCLES.
- With LONG_CYCLES>0, o_long asserts LONG_CYCLES cycles after the o_press cycle, i.e. at edge k+1+DEBOUNCE_CYCLES+LONG_CYCLES.

Boundary conditions:
- Raw level returns to the accepted level on the edge where cnt == DEBOUNCE_CYCLES−1: no change is accepted and cnt ← 0.
- Release before LONG_CYCLES elapses: no o_long.
  - Release is accepted on the same edge hcnt would reach LONG_CYCLES: o_long does not assert.
  - The release takes effect because o_level is already 0 on the following evaluation.
- Reset mid-count or mid-hold: all state is cleared instantly, and no strobe is produced on reset release.
  - A button held through reset is re-debounced after release and produces o_press after the full latency.
- Simultaneous activity on several channels is handled with no arbitration.
- Every channel with identical stimulus timing produces identical, simultaneous strobes.

## Test plan
All scenarios use NUM_CH=4, DEBOUNCE_CYCLES=8, LONG_CYCLES=32 unless stated otherwise.

1. Reset then idle.
   - Stimulus: assert i_rst for 3 cycles, then hold i_buttons=4'b0000 for 100 cycles.
   - Required: all outputs stay 0.
   - Stimulus: assert i_rst asynchronously mid-cycle.
   - Required: outputs clear without waiting for a clock edge.
2. Clean press on channel 0.
   - Stimulus: i_buttons[0] rises before edge k and is held for 60 cycles.
   - Required: o_level[0]=1 and a 1-cycle o_press[0] at edge k+9.
   - Required: a 1-cycle o_long[0] at edge k+41.
   - Required: other channels stay 0.
3. Bounce rejection on channel 1.
   - Stimulus: toggle i_buttons[1] with high pulses of 1, 3 and 7 cycles separated by 2-cycle lows, then hold high.
   - Required: no o_press[1] until 9 edges after the final rise, and exactly one o_press[1].
4. Release before long press on channel 2.
   - Stimulus: press, then release 20 cycles after o_press[2].
   - Required: o_release[2] at 9 edges after s1 captures the release.
   - Required: o_long[2] never asserts, and o_level[2] returns to 0.
5. Active-low mode.
   - Setup: ACTIVE_HIGH=0, i_buttons idle at 4'b1111.
   - Stimulus: drive channel 3 low, then high.
   - Required: o_press[3] on the low edge and o_release[3] on the high edge, each after the full latency.
   - Required: o_level[3] is 1 while the pin is low.
6. Concurrent channels plus reset mid-count.
   - Stimulus: press channels 0 and 3 on the same cycle.
   - Required: simultaneous o_press on both.
   - Stimulus: assert i_rst at cnt=5 on channel 1 during a press.
   - Required: no strobe on reset release.
   - Required: with the button still held, o_press[1] arrives 9 edges after the first post-reset s1 capture.
